// File: rtl/bcd_pkg.sv
// bcd_pkg
// Shared definitions for the serial binary-to-BCD converter:
//   state_t      - converter FSM states (IDLE, SHIFT, DONE)
//   DIGIT_W      - bits per BCD digit
//   ADD3_THRESH  - digit value at or above which double-dabble adds 3
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DIGIT_W     = 4;
   localparam int ADD3_THRESH = 5;

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj
// Combinational double-dabble correction for one BCD digit: adds 3 when the
// digit is 5 or more, so the following left shift carries into the next digit.
// Ports:
//   digit    in  DIGIT_W  current digit value
//   adjusted out DIGIT_W  digit after the conditional +3
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   output logic [DIGIT_W-1:0] adjusted
);

   always_comb begin
      if (digit >= DIGIT_W'(ADD3_THRESH))
         adjusted = digit + DIGIT_W'(3);
      else
         adjusted = digit;
   end

endmodule

// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial
// Serial (one bit per clock) binary-to-BCD converter using double-dabble,
// with optional two's-complement input and an overflow flag when the value
// does not fit in DIGITS decimal digits.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   request conversion (taken only while in_ready=1)
//   in_bin     in   WIDTH-bit operand, captured on the accept edge
//   is_signed  in   1 = in_bin is two's complement
//   in_ready   out  high in IDLE
//   out_valid  out  high in DONE
//   out_ready  in   consumer takes the result while out_valid=1
//   bcd        out  4*DIGITS packed digits, ones digit in [3:0]
//   neg        out  signed operand was negative (bcd is the magnitude)
//   ovf        out  value needed more than DIGITS digits (bcd is mod 10^DIGITS)
module bin2bcd_serial
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [WIDTH-1:0]          in_bin,
   input  logic                      is_signed,
   output logic                      in_ready,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DIGIT_W*DIGITS-1:0] bcd,
   output logic                      neg,
   output logic                      ovf
);

   localparam int BCD_W = DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   state_t             state;
   logic [CNT_W-1:0]   count;
   logic [BCD_W-1:0]   digits;
   logic [BCD_W-1:0]   adj_digits;
   logic [WIDTH-1:0]   mag;
   logic               neg_work;
   logic               ovf_work;
   logic               take_neg;

   assign take_neg = is_signed & in_bin[WIDTH-1];

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_adj
         bcd_digit_adj u_adj (
            .digit    (digits[gi*DIGIT_W +: DIGIT_W]),
            .adjusted (adj_digits[gi*DIGIT_W +: DIGIT_W])
         );
      end
   endgenerate

   // count runs 0..WIDTH: WIDTH shift iterations, then one extra edge that
   // publishes the working digits to the output registers and enters DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         digits    <= '0;
         mag       <= '0;
         neg_work  <= 1'b0;
         ovf_work  <= 1'b0;
         bcd       <= '0;
         neg       <= 1'b0;
         ovf       <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= SHIFT;
                  in_ready <= 1'b0;
                  count    <= '0;
                  digits   <= '0;
                  ovf_work <= 1'b0;
                  neg_work <= take_neg;
                  // Negating the signed minimum yields the same bit pattern,
                  // which read as unsigned is exactly 2^(WIDTH-1).
                  mag      <= take_neg ? (~in_bin + ONE) : in_bin;
               end
            end
            SHIFT: begin
               if (count == LAST) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  bcd       <= digits;
                  neg       <= neg_work;
                  ovf       <= ovf_work;
               end else begin
                  // Top bit of the adjusted digits falls off the end: that is
                  // a carry out of the most significant decimal digit.
                  {digits, mag} <= {adj_digits[BCD_W-2:0], mag, 1'b0};
                  ovf_work      <= ovf_work | adj_digits[BCD_W-1];
                  count         <= count + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_serial.sv
// tb_bin2bcd_serial
// Self-checking bench for bin2bcd_serial: an 8-bit/3-digit instance and a
// 16-bit/4-digit instance share clock and reset. Expected results come from
// an arithmetic reference model (divide/modulo by 10).
module tb_bin2bcd_serial;

   logic        clk;
   logic        rst;

   logic        start8, sgn8, out_ready8, in_ready8, out_valid8, neg8, ovf8;
   logic [7:0]  in8;
   logic [11:0] bcd8;

   logic        start16, sgn16, out_ready16, in_ready16, out_valid16, neg16, ovf16;
   logic [15:0] in16;
   logic [15:0] bcd16;

   int checks;
   int errors;

   bin2bcd_serial #(.WIDTH(8), .DIGITS(3)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .start     (start8),
      .in_bin    (in8),
      .is_signed (sgn8),
      .in_ready  (in_ready8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .bcd       (bcd8),
      .neg       (neg8),
      .ovf       (ovf8)
   );

   bin2bcd_serial #(.WIDTH(16), .DIGITS(4)) dut16 (
      .clk       (clk),
      .rst       (rst),
      .start     (start16),
      .in_bin    (in16),
      .is_signed (sgn16),
      .in_ready  (in_ready16),
      .out_valid (out_valid16),
      .out_ready (out_ready16),
      .bcd       (bcd16),
      .neg       (neg16),
      .ovf       (ovf16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: magnitude from signed/unsigned reading, then decimal digits.
   function automatic void model(input longint unsigned v, input int w, input int d,
                                 input bit s, output logic [39:0] b,
                                 output bit n, output bit o);
      longint unsigned mag, lim, m, top;
      top = longint'(1) << (w - 1);
      n   = s && (v >= top);
      mag = n ? ((top << 1) - v) : v;
      lim = 1;
      for (int i = 0; i < d; i++) lim = lim * 10;
      o = (mag >= lim);
      m = mag % lim;
      b = '0;
      for (int i = 0; i < d; i++) begin
         b[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
   endfunction

   // Runs one conversion; phase on entry/exit is 1 time unit after a rising edge.
   task automatic do_conv(input bit wide, input logic [15:0] v, input bit s,
                          input bit release_out, output int lat,
                          output logic [15:0] b, output logic n, output logic o);
      if (wide) begin start16 = 1'b1; in16 = v; sgn16 = s; end
      else begin start8 = 1'b1; in8 = v[7:0]; sgn8 = s; end
      @(posedge clk); #1;
      start8 = 1'b0; start16 = 1'b0;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!(wide ? out_valid16 : out_valid8) && lat < 100);
      b = wide ? bcd16 : {4'h0, bcd8};
      n = wide ? neg16 : neg8;
      o = wide ? ovf16 : ovf8;
      if (release_out) begin
         out_ready8 = 1'b1; out_ready16 = 1'b1;
         @(posedge clk); #1;
         out_ready8 = 1'b0; out_ready16 = 1'b0;
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({in_ready8, out_valid8, bcd8, neg8, ovf8} !== {1'b1, 1'b0, 12'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset8: got rdy=%b vld=%b bcd=%h neg=%b ovf=%b expected rdy=1 vld=0 bcd=000 neg=0 ovf=0",
                  in_ready8, out_valid8, bcd8, neg8, ovf8);
      end
      checks++;
      if ({in_ready16, out_valid16, bcd16, neg16, ovf16} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset16: got rdy=%b vld=%b bcd=%h neg=%b ovf=%b expected rdy=1 vld=0 bcd=0000 neg=0 ovf=0",
                  in_ready16, out_valid16, bcd16, neg16, ovf16);
      end
   endtask

   task automatic test_known();
      logic [15:0] vals [4] = '{16'd255, 16'h80, 16'hFF, 16'h00};
      bit          sgns [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      logic [11:0] exp_b [4] = '{12'h255, 12'h128, 12'h001, 12'h000};
      bit          exp_n [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      int lat; logic [15:0] b; logic n, o;
      for (int i = 0; i < 4; i++) begin
         do_conv(1'b0, vals[i], sgns[i], 1'b1, lat, b, n, o);
         checks++;
         if (lat !== 9 || b[11:0] !== exp_b[i] || n !== exp_n[i] || o !== 1'b0) begin
            errors++;
            $display("FAIL known in=%h s=%b: got lat=%0d bcd=%h neg=%b ovf=%b expected lat=9 bcd=%h neg=%b ovf=0",
                     vals[i], sgns[i], lat, b[11:0], n, o, exp_b[i], exp_n[i]);
         end
         $display("known in=%h s=%b -> bcd=%h neg=%b ovf=%b lat=%0d", vals[i], sgns[i], b[11:0], n, o, lat);
      end
   endtask

   task automatic test_ignore_start();
      int lat;
      start8 = 1'b1; in8 = 8'd203; sgn8 = 1'b0;
      @(posedge clk); #1;
      start8 = 1'b0; in8 = 8'd7;
      lat = 0;
      repeat (2) begin @(posedge clk); #1; lat++; end
      start8 = 1'b1; sgn8 = 1'b1; in8 = 8'hF0;
      @(posedge clk); #1; lat++;
      start8 = 1'b0; in8 = 8'd7;
      checks++;
      if (in_ready8 !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start_rdy: got in_ready=%b expected 0", in_ready8);
      end
      while (!out_valid8 && lat < 100) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat !== 9 || bcd8 !== 12'h203 || neg8 !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start: got lat=%0d bcd=%h neg=%b expected lat=9 bcd=203 neg=0", lat, bcd8, neg8);
      end
      $display("ignore_start -> bcd=%h lat=%0d", bcd8, lat);
      out_ready8 = 1'b1; @(posedge clk); #1; out_ready8 = 1'b0;
   endtask

   task automatic test_hold();
      int lat, bad; logic [15:0] b; logic n, o;
      logic [39:0] eb; bit en, eo;
      model(64'd200, 8, 3, 1'b1, eb, en, eo);
      do_conv(1'b0, 16'd200, 1'b1, 1'b0, lat, b, n, o);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin start8 = 1'b1; in8 = 8'd1; end
         @(posedge clk); #1;
         if (out_valid8 !== 1'b1 || bcd8 !== eb[11:0] || neg8 !== en) bad++;
      end
      start8 = 1'b0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL hold: got %0d unstable cycles (bcd=%h neg=%b) expected 0 (bcd=%h neg=%b)",
                  bad, bcd8, neg8, eb[11:0], en);
      end
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      checks++;
      if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
         errors++;
         $display("FAIL hold_release: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready8, out_valid8);
      end
      $display("hold 20 cycles -> bcd=%h neg=%b", bcd8, neg8);
   endtask

   task automatic test_back_to_back();
      int lat; logic [15:0] b; logic n, o;
      do_conv(1'b0, 16'd99, 1'b0, 1'b0, lat, b, n, o);
      out_ready8 = 1'b1; start8 = 1'b1; in8 = 8'd42; sgn8 = 1'b0;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      checks++;
      if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_exit: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready8, out_valid8);
      end
      @(posedge clk); #1;
      start8 = 1'b0;
      checks++;
      if (in_ready8 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept: got in_ready=%b expected 0", in_ready8);
      end
      lat = 0;
      while (!out_valid8 && lat < 100) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat !== 9 || bcd8 !== 12'h042) begin
         errors++;
         $display("FAIL b2b_result: got lat=%0d bcd=%h expected lat=9 bcd=042", lat, bcd8);
      end
      $display("back_to_back -> bcd=%h lat=%0d", bcd8, lat);
      out_ready8 = 1'b1; @(posedge clk); #1; out_ready8 = 1'b0;
   endtask

   task automatic test_async_reset();
      int bad, lat; logic [15:0] b; logic n, o;
      // Reset mid-SHIFT, checked between clock edges.
      start8 = 1'b1; in8 = 8'hFF; sgn8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({in_ready8, out_valid8, bcd8, neg8, ovf8} !== {1'b1, 1'b0, 12'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset: got rdy=%b vld=%b bcd=%h neg=%b ovf=%b expected rdy=1 vld=0 bcd=000 neg=0 ovf=0",
                  in_ready8, out_valid8, bcd8, neg8, ovf8);
      end
      #1 rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL reset_shift_release: got %0d cycles with vld=1 or rdy=0 expected 0", bad);
      end
      // Reset while holding in DONE.
      do_conv(1'b0, 16'd77, 1'b0, 1'b0, lat, b, n, o);
      #2 rst = 1'b1;
      #1 rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || bcd8 !== 12'h0) begin
         errors++;
         $display("FAIL reset_done: got vld=%b rdy=%b bcd=%h expected vld=0 rdy=1 bcd=000", out_valid8, in_ready8, bcd8);
      end
      $display("async_reset -> rdy=%b vld=%b bcd=%h", in_ready8, out_valid8, bcd8);
   endtask

   task automatic test_sweep();
      int lat, bad; logic [15:0] b; logic n, o;
      logic [39:0] eb; bit en, eo;
      bad = 0;
      for (int s = 0; s < 2; s++) begin
         for (int v = 0; v < 256; v++) begin
            model(longint'(v), 8, 3, s[0], eb, en, eo);
            do_conv(1'b0, 16'(v), s[0], 1'b1, lat, b, n, o);
            checks++;
            if (lat !== 9 || b[11:0] !== eb[11:0] || n !== en || o !== eo) begin
               errors++; bad++;
               $display("FAIL sweep in=%0d s=%0d: got lat=%0d bcd=%h neg=%b ovf=%b expected lat=9 bcd=%h neg=%b ovf=%b",
                        v, s, lat, b[11:0], n, o, eb[11:0], en, eo);
            end
         end
      end
      $display("sweep 8-bit signed/unsigned: %0d mismatching conversions", bad);
   endtask

   task automatic test_wide();
      int lat; logic [15:0] b, v; logic n, o; bit s;
      logic [39:0] eb; bit en, eo;
      do_conv(1'b1, 16'hFFFF, 1'b0, 1'b1, lat, b, n, o);
      checks++;
      if (lat !== 17 || b !== 16'h5535 || n !== 1'b0 || o !== 1'b1) begin
         errors++;
         $display("FAIL wide_65535: got lat=%0d bcd=%h neg=%b ovf=%b expected lat=17 bcd=5535 neg=0 ovf=1", lat, b, n, o);
      end
      $display("wide in=ffff -> bcd=%h ovf=%b lat=%0d", b, o, lat);
      for (int i = 0; i < 30; i++) begin
         v = 16'($urandom);
         s = 1'($urandom);
         model(longint'(v), 16, 4, s, eb, en, eo);
         do_conv(1'b1, v, s, 1'b1, lat, b, n, o);
         checks++;
         if (lat !== 17 || b !== eb[15:0] || n !== en || o !== eo) begin
            errors++;
            $display("FAIL wide_rand in=%h s=%b: got lat=%0d bcd=%h neg=%b ovf=%b expected lat=17 bcd=%h neg=%b ovf=%b",
                     v, s, lat, b, n, o, eb[15:0], en, eo);
         end
         $display("wide in=%h s=%b -> bcd=%h neg=%b ovf=%b", v, s, b, n, o);
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1;
      start8 = 1'b0; in8 = '0; sgn8 = 1'b0; out_ready8 = 1'b0;
      start16 = 1'b0; in16 = '0; sgn16 = 1'b0; out_ready16 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      test_known();
      test_ignore_start();
      test_hold();
      test_back_to_back();
      test_async_reset();
      test_sweep();
      test_wide();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
